rx_low_pass_ctrl: RTL
=====================

RX_LOW_PASS_CTRL -- requirements
Module: rx_low_pass_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 128, taps read per sample (legal range 2..128).
REQ-002 SHALL have parameter ADDR_W, default 7, sample BRAM address width.
REQ-003 SHALL have parameter DATA_W, default 16, sample width.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rrx_rst  in  1  reset; synchronous, active-high.
- smp_valid  in  1  new input sample strobe.
- smp_data  in  DATA_W  input sample.
- busy  out  1  controller not in IDLE.
- overrun  out  1  sticky; sample arrived while busy.
- bram_ena  out  1  BRAM port A enable.
- bram_wea  out  1  BRAM port A write enable.
- bram_addra  out  ADDR_W  BRAM write address.
- bram_dia  out  DATA_W  BRAM write data.
- bram_enb  out  1  BRAM port B read enable.
- bram_addrb  out  ADDR_W  BRAM read address.
- bram_dob  in  DATA_W  BRAM read data; registered, 1-cycle latency.
- tap_valid  out  1  tap_data valid for the MAC.
- tap_data  out  DATA_W  tap sample, equal to bram_dob.
- tap_idx  out  ADDR_W  tap number k, used for coefficient lookup.
- tap_first  out  1  marks k=0.
- tap_last  out  1  marks k=NTAPS-1.
- done  out  1  one-cycle pulse when a sample's tap sweep is complete.

Function
REQ-005 SHALL implement FSM states CLR, IDLE, WR, RD, DRAIN, DONE.
REQ-006 CLR SHALL write 0 to addresses 0..127, one per cycle (ena=wea=1, addra=counter), then go to IDLE after address 127; duration 128 cycles.
REQ-007 IDLE with smp_valid=1 SHALL register smp_data and go to WR; otherwise SHALL stay in IDLE.
REQ-008 WR SHALL last 1 cycle, driving ena=wea=1, addra=wr_ptr, dia=registered sample, then go to RD.
REQ-009 RD SHALL last NTAPS cycles with enb=1 and addrb=(wr_ptr-k) mod 128 for k=0..NTAPS-1, newest sample first.
REQ-010 DRAIN SHALL last 1 cycle with enb=0, then go to DONE.
REQ-011 tap_valid, tap_idx, tap_first and tap_last SHALL be the enb/k/first/last values delayed by one register, aligned with bram_dob.
REQ-012 DONE SHALL pulse done=1 for 1 cycle, set wr_ptr=(wr_ptr+1) mod 128 (127 wraps to 0), then go to IDLE.
REQ-013 Latency SHALL be as follows, for smp_valid accepted at cycle t:
- write at t+1;
- tap_valid over t+3..t+NTAPS+2;
- done at t+NTAPS+3;
- next sample accepted from t+NTAPS+4.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 smp_valid in any state other than IDLE SHALL drop the sample and set overrun=1 until reset; the sweep in progress SHALL be unaffected.
REQ-016 bram_ena/bram_wea SHALL be asserted only in CLR and WR, and bram_enb only in RD; write and read SHALL never target the same cycle.
REQ-017 Outputs SHALL be undefined-free: addresses and data SHALL be 0 whenever their enable is 0.

Reset
REQ-018 rrx_rst=1 SHALL force the state to CLR with clear counter=0, wr_ptr=0 and overrun=0.
REQ-019 During reset, all outputs SHALL be 0 except busy=1.
REQ-020 Reset asserted mid-operation (WR/RD/DRAIN) SHALL abort immediately: no done, no further tap_valid, and BRAM history re-zeroed by CLR.

Structure
REQ-021 ADDR_W, DATA_W, BRAM depth 128 and the FSM state encoding SHALL live in shared package rx_pkg.
REQ-022 No sub-module is required; the sample BRAM SHALL be instantiated beside this block in the rx low-pass parent.

Verification
REQ-023 Reset then idle: 128 CLR writes of 0 to addresses 0..127, busy=1 for 128 cycles after reset release, then busy=0.
REQ-024 Single sample 0x1234, NTAPS=128: write to addr 0 at t+1; tap k=0 data=0x1234 with tap_first; taps k=1..127 read addresses 127..1 with data 0; tap_last at k=127; done at t+131.
REQ-025 Three samples 0x0001, 0x0002, 0x0003 spaced 140 cycles apart: third sweep taps k=0..2 = 3, 2, 1 and addrb sequence 2, 1, 0, 127.
REQ-026 130 samples: wr_ptr wraps 127->0, and sample 129 overwrites addr 0.
REQ-027 smp_valid at t+5 of a sweep: sample dropped, overrun=1 sticky, and current sweep taps unchanged.
REQ-028 rrx_rst asserted at k=40 of a sweep: tap_valid=0 next cycle, no done, CLR re-runs, and the next sample's taps k>=1 read 0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and FSM encoding for the rx low-pass sample-history controller.
package rx_pkg;

    localparam int RX_ADDR_W = 7;
    localparam int RX_DATA_W = 16;
    localparam int RX_DEPTH  = 128;

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_WR    = 3'd2,
        S_RD    = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/rx_low_pass_ctrl.sv
// Sample-history controller: writes each new sample into a circular BRAM and sweeps
// the NTAPS most recent samples out, newest first, as a tap stream for the FIR MAC.
module rx_low_pass_ctrl
    import rx_pkg::*;
#(
    parameter int NTAPS  = 128,
    parameter int ADDR_W = RX_ADDR_W,
    parameter int DATA_W = RX_DATA_W
) (
    input  logic              clk,
    input  logic              rrx_rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              overrun,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dia,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_dob,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_idx,
    output logic              tap_first,
    output logic              tap_last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RX_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NTAPS - 1);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_k;
    logic              r_overrun;
    logic [DATA_W-1:0] r_smp;
    logic              r_tap_vld;
    logic [ADDR_W-1:0] r_tap_idx;
    logic              r_tap_first;
    logic              r_tap_last;

    logic              w_ena;
    logic              w_wea;
    logic [ADDR_W-1:0] w_addra;
    logic [DATA_W-1:0] w_dia;
    logic              w_enb;
    logic [ADDR_W-1:0] w_addrb;
    logic              w_done;
    logic              w_tap_on;

    always_ff @(posedge clk) begin
        if (rrx_rst) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ena       = 1'b0;
        w_wea       = 1'b0;
        w_addra     = '0;
        w_dia       = '0;
        w_enb       = 1'b0;
        w_addrb     = '0;
        w_done      = 1'b0;
        case (r_state)
            S_CLR: begin
                w_ena   = 1'b1;
                w_wea   = 1'b1;
                w_addra = r_clr_cnt;
                if (r_clr_cnt == LAST_ADDR) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (smp_valid) w_state_nxt = S_WR;
            end
            S_WR: begin
                w_ena       = 1'b1;
                w_wea       = 1'b1;
                w_addra     = r_wr_ptr;
                w_dia       = r_smp;
                w_state_nxt = S_RD;
            end
            S_RD: begin
                // Walk backwards from the newest sample; address arithmetic wraps with the ring.
                w_enb   = 1'b1;
                w_addrb = r_wr_ptr - r_k;
                if (r_k == LAST_TAP) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rrx_rst) begin
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_k       <= '0;
            r_overrun <= 1'b0;
            r_tap_vld <= 1'b0;
        end else begin
            if (r_state == S_CLR) r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_state == S_DONE) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (smp_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
            r_k       <= (r_state == S_RD) ? r_k + 1'b1 : '0;
            r_tap_vld <= w_enb;
        end
    end

    // Tap side-band is delayed one cycle to line up with the registered BRAM read port.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && smp_valid) r_smp <= smp_data;
        r_tap_idx   <= r_k;
        r_tap_first <= (r_k == '0);
        r_tap_last  <= (r_k == LAST_TAP);
    end

    assign w_tap_on   = r_tap_vld & ~rrx_rst;

    assign busy       = rrx_rst | (r_state != S_IDLE);
    assign overrun    = r_overrun & ~rrx_rst;
    assign bram_ena   = w_ena & ~rrx_rst;
    assign bram_wea   = w_wea & ~rrx_rst;
    assign bram_addra = rrx_rst ? '0 : w_addra;
    assign bram_dia   = rrx_rst ? '0 : w_dia;
    assign bram_enb   = w_enb & ~rrx_rst;
    assign bram_addrb = rrx_rst ? '0 : w_addrb;
    assign tap_valid  = w_tap_on;
    assign tap_data   = w_tap_on ? bram_dob : '0;
    assign tap_idx    = w_tap_on ? r_tap_idx : '0;
    assign tap_first  = w_tap_on & r_tap_first;
    assign tap_last   = w_tap_on & r_tap_last;
    assign done       = w_done & ~rrx_rst;

endmodule
